mux_rr_scheduler: RTL
=====================

// Module: mux_rr_scheduler
// PURPOSE
//  Round-robin scheduler for the shared 16-bit result bus fed by the four operation units (00, 01, 10, 11).
//  Each unit raises REQ; the block grants one unit at a time, latches its word and drives the select code.
//  The granted word is held stable on OUT_DATA for HOLD_CYCLES clocks (display/consumer dwell time).
//  Replaces the data-derived select with an explicit, fair, registered selection.
// PARAMETERS
//  WIDTH        16  data width of each source and of OUT_DATA
//  HOLD_CYCLES  4   clocks a granted word stays valid on OUT_DATA; legal range >= 1
// PORTS
//  CLK        in   1      clock; all logic on rising edge
//  RST        in   1      synchronous, active-high reset
//  REQ        in   4      REQ[i] = source i has a word ready (i = 0..3 -> units 00..11)
//  IN_00      in   WIDTH  data of source 0
//  IN_01      in   WIDTH  data of source 1
//  IN_10      in   WIDTH  data of source 2
//  IN_11      in   WIDTH  data of source 3
//  ACK        out  4      one-hot, one-cycle pulse: word of source i captured
//  OUT_DATA   out  WIDTH  captured word, frozen while OUT_VALID=1
//  OUT_SEL    out  2      index of the source currently on OUT_DATA
//  OUT_VALID  out  1      OUT_DATA holds a granted word
//  BUSY       out  1      1 while in HOLD
// BEHAVIOUR
//  - One clock CLK; reset synchronous, active-high on RST. All outputs registered.
//  - Reset (RST=1 at edge): state IDLE, OUT_DATA=0, OUT_SEL=2'b00, OUT_VALID=0, ACK=4'b0, BUSY=0,
//    PTR=2'd0, hold counter CNT=0. Reset mid-HOLD aborts; pending requests are not remembered.
//  - Effective request EREQ = REQ & ~ACK (a source's REQ is ignored in its own ACK cycle; source must
//    drop REQ on seeing ACK).
//  - Winner: first i with EREQ[i]=1 searching PTR, PTR+1, ... modulo 4 (3 wraps to 0).
//  - GRANT event (edge where state=IDLE or (state=HOLD and CNT=0), and EREQ!=0):
//    OUT_DATA<=IN_winner, OUT_SEL<=winner, OUT_VALID<=1, ACK<=onehot(winner), BUSY<=1,
//    CNT<=HOLD_CYCLES-1, PTR<=winner+1 mod 4, state<=HOLD.  Latency REQ->ACK/OUT_VALID = 1 clock.
//  - HOLD, CNT>0: CNT<=CNT-1, ACK<=0, OUT_DATA/OUT_SEL unchanged regardless of IN_xx changes.
//  - HOLD, CNT=0, EREQ=0: state<=IDLE, OUT_VALID<=0, BUSY<=0, ACK<=0; OUT_DATA/OUT_SEL keep last value.
//  - HOLD, CNT=0, EREQ!=0: back-to-back GRANT, no idle bubble; OUT_VALID stays 1.
//  - Hence each word is valid exactly HOLD_CYCLES clocks; HOLD_CYCLES=1 gives one grant per clock.
//  - IDLE, EREQ=0: all outputs hold, ACK=0.
//  - REQ dropped before its grant edge: no grant, no ACK. Simultaneous requests resolved only by PTR.
//  - CNT width $clog2(HOLD_CYCLES+1); no arithmetic on data; PTR arithmetic is 2-bit wrap.
// STRUCTURE
//  - Package mux_sched_pkg: NUM_SRC=4, SEL_W=2, typedef enum logic {IDLE, HOLD} sched_state_t,
//    source index constants SRC_00..SRC_11 = 2'd0..2'd3.
//  - Sub-module rr_picker (combinational): in EREQ[3:0], PTR[1:0]; out any, winner[1:0].
//  - Top: state register, CNT, PTR, output registers, data capture mux on winner.
// TESTING
//  1. RST held 2 clocks with REQ=4'hF -> all outputs 0, no ACK; release -> first grant to source 0.
//  2. REQ=4'b0100, IN_10=16'hA5A5, HOLD_CYCLES=4 -> next clock ACK=4'b0100, OUT_SEL=2, OUT_DATA=A5A5,
//     OUT_VALID high exactly 4 clocks then 0; IN_10 changed during hold does not affect OUT_DATA.
//  3. REQ=4'hF held (each source drops REQ 1 clock after its ACK, re-raises later) -> grant order
//     0,1,2,3,0; OUT_VALID continuously 1, no bubble between grants.
//  4. PTR=3 (after granting 2), REQ=4'b1001 simultaneously -> source 3 granted, then 0 (wrap).
//  5. HOLD_CYCLES=1, REQ=4'b0011 -> ACK 4'b0001 then 4'b0010 on consecutive clocks, OUT_DATA follows.
//  6. RST asserted during 2nd hold clock -> next edge OUT_VALID=0, ACK=0, OUT_DATA=0, PTR=0; pending
//     REQ=4'b1000 then granted 1 clock after RST release.

Source files
------------

// File: rtl/mux_sched_pkg.sv
// mux_sched_pkg: shared constants and types for the round-robin result-bus scheduler
package mux_sched_pkg;
    localparam int NUM_SRC = 4;
    localparam int SEL_W   = 2;
    typedef enum logic {IDLE, HOLD} sched_state_t;
    localparam logic [SEL_W-1:0] SRC_00 = 2'd0;
    localparam logic [SEL_W-1:0] SRC_01 = 2'd1;
    localparam logic [SEL_W-1:0] SRC_10 = 2'd2;
    localparam logic [SEL_W-1:0] SRC_11 = 2'd3;
endpackage

// File: rtl/mux_rr_scheduler_rr_picker.sv
// rr_picker: first requesting source found starting at the priority pointer, wrapping modulo 4
module rr_picker
    import mux_sched_pkg::*;
(
    input  logic [NUM_SRC-1:0] i_ereq,
    input  logic [SEL_W-1:0]   i_ptr,
    output logic               o_any,
    output logic [SEL_W-1:0]   o_winner
);
    logic [SEL_W-1:0] w_idx;
    logic             w_found;
    always_comb begin
        o_winner = i_ptr;
        w_found  = 1'b0;
        w_idx    = i_ptr;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_idx = i_ptr + SEL_W'(k);
            if (!w_found && i_ereq[w_idx]) begin
                o_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end
    assign o_any = |i_ereq;
endmodule

// File: rtl/mux_rr_scheduler.sv
// mux_rr_scheduler: fair round-robin grant of four sources onto one result bus,
// each granted word held stable for HOLD_CYCLES clocks
module mux_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int HOLD_CYCLES = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [WIDTH-1:0]   i_in_00,
    input  logic [WIDTH-1:0]   i_in_01,
    input  logic [WIDTH-1:0]   i_in_10,
    input  logic [WIDTH-1:0]   i_in_11,
    output logic [NUM_SRC-1:0] o_ack,
    output logic [WIDTH-1:0]   o_out_data,
    output logic [SEL_W-1:0]   o_out_sel,
    output logic               o_out_valid,
    output logic               o_busy
);
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    sched_state_t       r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [SEL_W-1:0]   r_ptr;
    logic [SEL_W-1:0]   r_sel;
    logic [NUM_SRC-1:0] r_ack;
    logic [WIDTH-1:0]   r_data;
    logic               r_valid;
    logic               r_busy;

    logic [NUM_SRC-1:0] w_ereq;
    logic               w_any;
    logic               w_grant;
    logic [SEL_W-1:0]   w_winner;
    logic [WIDTH-1:0]   w_data;

    // A source's request is ignored in the cycle it is being acknowledged
    assign w_ereq = i_req & ~r_ack;

    rr_picker u_picker (
        .i_ereq   (w_ereq),
        .i_ptr    (r_ptr),
        .o_any    (w_any),
        .o_winner (w_winner)
    );

    always_comb
        w_data = (w_winner == SRC_00) ? i_in_00 :
                 (w_winner == SRC_01) ? i_in_01 :
                 (w_winner == SRC_10) ? i_in_10 : i_in_11;

    assign w_grant = w_any && (r_state == IDLE || r_cnt == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ptr   <= SRC_00;
            r_sel   <= SRC_00;
            r_ack   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ack <= '0;
            if (w_grant) begin
                r_state <= HOLD;
                r_data  <= w_data;
                r_sel   <= w_winner;
                r_valid <= 1'b1;
                r_busy  <= 1'b1;
                r_ack   <= NUM_SRC'(1) << w_winner;
                r_cnt   <= CNT_W'(HOLD_CYCLES - 1);
                r_ptr   <= w_winner + SEL_W'(1);
            end else if (r_state == HOLD) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end else begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            end
        end
    end

    assign o_ack       = r_ack;
    assign o_out_data  = r_data;
    assign o_out_sel   = r_sel;
    assign o_out_valid = r_valid;
    assign o_busy      = r_busy;
endmodule
